// File: rtl/echo_width_meter_pkg.sv
// Shared types and default sizing for the echo pulse-width meter.
// Build option: ECHO_GLITCH_FILTER_EN (see echo_width_meter).
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int CNT_W_DEF       = 24;
  localparam int TIMEOUT_CYC_DEF = 3800000;  // 38 ms at 100 MHz
  localparam int FILTER_LEN_DEF  = 4;

endpackage

// File: rtl/echo_width_meter_if.sv
// Port bundle between the ranging controller and the echo width meter.
interface echo_width_meter_if #(
  parameter int CNT_W = echo_pkg::CNT_W_DEF
);
  import echo_pkg::*;

  // start is a one-cycle request taken only when the meter is idle (no ready);
  // valid and timeout are one-cycle strobes with no backpressure, width is
  // stable from the valid cycle until the next valid.
  logic             start;
  logic             echo;
  logic [CNT_W-1:0] width;
  logic             valid;
  logic             timeout;
  logic             busy;
  state_t           dbg_state;

  modport master (
    output start, echo,
    input  width, valid, timeout, busy, dbg_state
  );

  modport slave (
    input  start, echo,
    output width, valid, timeout, busy, dbg_state
  );

endinterface

// File: rtl/echo_width_meter_sync.sv
// Two-flop synchronizer for the raw echo pin with registered edge flags
// aligned to the synchronized level echo_s.
module echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic echo,
  output logic echo_s,
  output logic rise,
  output logic fall
);

  logic meta;

  // rise/fall are high in the first cycle echo_s shows the new level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= 1'b0;
      echo_s <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta   <= echo;
      echo_s <= meta;
      rise   <= meta & ~echo_s;
      fall   <= ~meta & echo_s;
    end
  end

endmodule

// File: rtl/echo_width_meter.sv
// Measures the echo high time in clk cycles after a start pulse.
// Build option: ECHO_GLITCH_FILTER_EN requires FILTER_LEN high cycles to accept a rise.
module echo_width_meter
  import echo_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
  input logic               clk,
  input logic               reset,
  echo_width_meter_if.slave bus
);

  localparam int RUN_W = $clog2(FILTER_LEN + 1);
`ifdef ECHO_GLITCH_FILTER_EN
  localparam int RISE_LEN = FILTER_LEN;
`else
  localparam int RISE_LEN = 1;
`endif
  localparam logic [RUN_W-1:0] RISE_LEN_R = RUN_W'(RISE_LEN);
  localparam logic [CNT_W-1:0] RISE_CNT   = CNT_W'(RISE_LEN);
  localparam logic [CNT_W-1:0] TMO        = CNT_W'(TIMEOUT_CYC);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [RUN_W-1:0] run_len;
  logic [RUN_W-1:0] run_nxt;
  logic [CNT_W-1:0] width_q;
  logic             valid_q;
  logic             timeout_q;
  logic             echo_s;
  logic             rise;
  logic             fall;

  echo_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .echo   (bus.echo),
    .echo_s (echo_s),
    .rise   (rise),
    .fall   (fall)
  );

  // Length of the current qualified high run while ARMED. A rise seen in the
  // first ARMED cycle (cnt==0) is a stale level from before arming.
  always_comb begin
    run_nxt = '0;
    if (state == ARMED) begin
      if (rise && cnt != '0)
        run_nxt = RUN_W'(1);
      else if (echo_s && run_len != '0)
        run_nxt = run_len + RUN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      run_len   <= '0;
      width_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      run_len   <= run_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= ARMED;
            cnt   <= '0;
          end
        end
        ARMED: begin
          // Accepted cycles already count toward the width.
          if (run_nxt == RISE_LEN_R) begin
            state <= MEASURE;
            cnt   <= RISE_CNT;
          end else if (cnt + CNT_W'(1) == TMO) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MEASURE: begin
          if (fall) begin
            width_q <= cnt;
            valid_q <= 1'b1;
            state   <= IDLE;
          end else if (cnt == TMO) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.width     = width_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = (state == ARMED) || (state == MEASURE);
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_echo_width_meter.sv
// Directed and randomized checks of echo_width_meter against a waveform-level model.
module tb_echo_width_meter;
  import echo_pkg::*;

  localparam int CNT_W = 24;
  localparam int T     = 1000;
`ifdef ECHO_GLITCH_FILTER_EN
  localparam int F = 4;
`else
  localparam int F = 1;
`endif
  localparam int WLEN = 4096;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  echo_width_meter_if #(.CNT_W(CNT_W)) bus ();

  echo_width_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(T),
    .FILTER_LEN (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int               n_tests = 0;
  int               n_fail  = 0;
  bit               wav [WLEN];
  bit               stv [WLEN];
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] prev_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_wav();
    for (int i = 0; i < WLEN; i++) begin
      wav[i] = 1'b0;
      stv[i] = 1'b0;
    end
  endtask

  task automatic set_hi(input int a, input int b);
    for (int i = a; i < b; i++) wav[i] = 1'b1;
  endtask

  // wav[k] is the raw echo level seen at clock edge k; start is taken at edge s.
  // The meter reacts at edge k to the raw level of edge k-2. Outcome: the first
  // high run that starts at least two edges after arming and lasts F samples
  // is accepted, unless T edges pass first; its full length is the width.
  function automatic void model(input int s, output bit is_valid, output int ev, output int wd);
    int r0;
    int c;
    int n;
    bit ok;
    r0 = -1;
    for (int k = s + 1; k <= s + T && r0 < 0; k++) begin
      c = k - F + 1;
      if (c >= s + 2 && wav[c-3] == 1'b0) begin
        ok = 1'b1;
        for (int i = c - 2; i <= k - 2; i++) if (!wav[i]) ok = 1'b0;
        if (ok) r0 = c;
      end
    end
    wd = 0;
    if (r0 < 0) begin
      is_valid = 1'b0;
      ev       = s + T;
    end else begin
      n = 0;
      while (n <= T && wav[r0-2+n]) n++;
      if (n <= T) begin
        is_valid = 1'b1;
        ev       = r0 + n;
        wd       = n;
      end else begin
        is_valid = 1'b0;
        ev       = r0 + T;
      end
    end
  endfunction

  task automatic run_txn(input string tag, input int s, input bit extra_starts);
    bit   isv;
    int   ev;
    int   wd;
    logic e_valid, e_to, e_busy;
    model(s, isv, ev, wd);
    stv[s] = 1'b1;
    if (extra_starts)
      for (int j = 0; j < 4; j++) stv[$urandom_range(ev, s + 1)] = 1'b1;
    if (isv) exp_q.push_back(CNT_W'(wd));
    for (int idx = 0; idx < ev + 3; idx++) begin
      bus.echo  = wav[idx];
      bus.start = stv[idx];
      @(posedge clk);
      #1;
      if (idx == ev && isv) prev_w = exp_q.pop_front();
      e_valid = isv && idx == ev;
      e_to    = !isv && idx == ev;
      e_busy  = idx >= s && idx < ev;
      check($sformatf("%s@%0d", tag, idx),
            {5'b0, bus.valid, bus.timeout, bus.busy, bus.width},
            {5'b0, e_valid, e_to, e_busy, prev_w});
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int s;
    int pos;
    int len;
    int ng;
    prev_w    = '0;
    bus.start = 1'b0;
    bus.echo  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {5'b0, bus.valid, bus.timeout, bus.busy, bus.width}, 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic 250-cycle pulse
    clear_wav(); set_hi(10, 260);
    run_txn("basic", 4, 1'b0);

    // No echo at all
    clear_wav();
    run_txn("no_echo", 4, 1'b0);

    // Echo stuck high
    clear_wav(); set_hi(10, 10 + T + 20);
    run_txn("stuck", 4, 1'b0);

    // Stale high level at arming, then a real 100-cycle pulse
    clear_wav(); set_hi(0, 26); set_hi(36, 136);
    run_txn("stale", 6, 1'b0);

    // Short glitch followed by a 60-cycle pulse
    clear_wav(); set_hi(10, 12); set_hi(16, 76);
    run_txn("glitch", 4, 1'b0);

    // Start pulses while busy are ignored
    clear_wav(); set_hi(10, 110);
    run_txn("start_busy", 4, 1'b1);

    // Asynchronous reset in the middle of a measurement
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.echo = 1'b1;
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("rst_mid_out", {5'b0, bus.valid, bus.timeout, bus.busy, bus.width}, 32'd0);
    check("rst_mid_state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    reset    = 1'b1;
    bus.echo = 1'b0;
    prev_w   = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_after@%0d", i),
            {5'b0, bus.valid, bus.timeout, bus.busy, bus.width}, 32'd0);
    end

    // Randomized waveforms: stale levels, glitches, pulses, overlong pulses
    for (int t = 0; t < 12; t++) begin
      clear_wav();
      s = 4 + $urandom_range(6, 0);
      if ($urandom_range(1, 0) == 1) set_hi(0, s + $urandom_range(5, 0));
      pos = s + $urandom_range(8, 2);
      ng  = $urandom_range(2, 0);
      for (int g = 0; g < ng; g++) begin
        len = $urandom_range(3, 1);
        set_hi(pos, pos + len);
        pos = pos + len + $urandom_range(4, 1);
      end
      case ($urandom_range(5, 0))
        0:       len = 0;
        1:       len = T + $urandom_range(5, 0);
        default: len = $urandom_range(400, 1);
      endcase
      set_hi(pos, pos + len);
      run_txn($sformatf("rand%0d", t), s, 1'($urandom_range(1, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_width_meter.md
Name: echo_width_meter

Overview:
Receive side of the ultrasonic ranging loop. A one-cycle start pulse from the trigger/one-shot logic arms the block. It then measures the high time of the sensor's asynchronous echo pin in clk cycles and reports the count with a one-cycle valid strobe. A no-echo or stuck-echo condition is reported on a separate timeout strobe. Downstream distance/display logic consumes width on valid.

Parameters:
CNT_W, 24, width of the pulse-width counter and the width output
TIMEOUT_CYC, 3800000, maximum cycles spent in each of ARMED and MEASURE (38 ms at 100 MHz); must be less than 2^CNT_W
FILTER_LEN, 4, consecutive high samples required to accept a rise (only with ECHO_GLITCH_FILTER_EN)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  one-cycle arm request; ignored unless in IDLE
echo  input  1  raw asynchronous echo pin from the sensor
width  output  CNT_W  last measured echo high time in clk cycles; holds until the next measurement
valid  output  1  one-cycle strobe; width updated in the same cycle
timeout  output  1  one-cycle strobe; no rise, or echo high too long
busy  output  1  high in ARMED and MEASURE

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, width=0, valid=0, timeout=0, busy=0.
  - Synchronizer flops and counter cleared.
  - Reset mid-measurement aborts with no strobe.
- echo passes through a 2-FF synchronizer; echo_s is the second flop. Rise and fall are derived from echo_s and a one-cycle delayed copy.
- States:
  - IDLE: start=1 -> ARMED, counter cleared.
  - ARMED: waits for a rising edge of echo_s. If echo_s is already high on entry (stale echo), it must first go low; a level is never accepted as a rise.
    - Rise -> MEASURE with counter=1.
    - Counter reaches TIMEOUT_CYC first -> timeout=1 for one cycle, -> IDLE, width unchanged.
  - MEASURE: counter increments each cycle echo_s=1.
    - First cycle with echo_s=0 -> width<=counter, valid=1 for one cycle, -> IDLE.
    - Counter reaches TIMEOUT_CYC while echo_s=1 -> timeout=1, width unchanged, -> IDLE.
- Width rule: echo_s high for exactly N cycles gives width=N. Counter saturation is impossible because TIMEOUT_CYC < 2^CNT_W.
- Latency: valid asserts on the 3rd rising clk edge after the first edge at which the raw echo is sampled low (2 sync + 1 state).
- valid and timeout are mutually exclusive and never both high.
- start during ARMED or MEASURE is ignored.
- start and an echo rise in the same IDLE cycle: the block enters ARMED and applies the stale-echo rule.
- The block returns to IDLE on the cycle of valid/timeout. The next start is accepted the following cycle.
- Illegal state encoding -> IDLE.

Optional Feature:
Macro ECHO_GLITCH_FILTER_EN.
- Defined:
  - In ARMED, a rise is accepted only after echo_s has been high for FILTER_LEN consecutive cycles. The block then enters MEASURE with counter=FILTER_LEN, so width still equals the total high time.
  - Shorter high runs are discarded and the block stays ARMED.
  - Falls are not filtered.
- Undefined: a single-cycle rise is accepted as described in Behaviour, and FILTER_LEN is unused.

Decomposition:
- Shared package echo_pkg:
  - state enum (IDLE, ARMED, MEASURE)
  - default CNT_W and TIMEOUT_CYC constants
- One sub-module, echo_sync: 2-FF synchronizer with registered rise/fall outputs, reset by the same active-low async reset.
- The FSM, counter and output registers stay in echo_width_meter.

Test Plan:
- Basic: TIMEOUT_CYC=1000. Reset, start pulse, echo high 250 cycles (clk-aligned) -> one valid with width=250, timeout=0, busy low after strobe.
- No echo: start, echo held 0 -> timeout=1 exactly once, 1000 cycles after ARMED entry; width keeps its previous value; valid never asserts.
- Stuck echo: start, echo rises and stays high -> timeout after counter hits 1000 in MEASURE; no valid.
- Stale echo: echo already high, then start; echo falls 20 cycles later, rises again and stays high 100 cycles -> width=100.
- Abort and ignore:
  - reset=0 mid-MEASURE -> all outputs 0 immediately, no strobe.
  - start pulses during MEASURE -> no restart; width matches the original pulse.
- Filter (ECHO_GLITCH_FILTER_EN, FILTER_LEN=4): 2-cycle glitch then a 60-cycle pulse -> single valid with width=60.
